lsu_mw_stage: RTL

Parametrised load/store unit for the memory/writeback (MW) stage of the RV32I pipeline. It replaces the single-cycle combinational load/store path with a handshaked, multi-cycle access engine. The engine talks to a data memory over a req/gnt/rvalid interface, stalls the pipeline while an access is outstanding, and splits word-crossing misaligned accesses into two aligned beats. It sits between the MW pipeline register and the data memory; its stall output is ORed into the hazard unit's MW stall.

---
 rtl/lsu_mw_stage_if.sv | 39 +++
 rtl/lsu_mw_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mw_stage_if.sv
// Data-memory bus between the MW-stage load/store unit and the data memory.
// The LSU drives the request side (master). The memory answers with
// gnt/rvalid/rdata (slave).
interface lsu_mw_stage_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_mw_stage.sv
// Multi-cycle load/store engine for the RV32I MW stage.
// It issues each access over a req/gnt/rvalid memory bus and stalls the pipeline
// until the access completes. A word-crossing misaligned access becomes two
// aligned beats. When MISALIGN_SPLIT is 0, the unit refuses misaligned accesses
// with misalign_exc instead.
module lsu_mw_stage #(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_mw,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign_exc,
  lsu_mw_stage_if.master    mem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Size / alignment helpers
  // ---------------------------------------------------------------------------

  // Access size in bytes from funct3[1:0]: byte, half, or word.
  function automatic logic [2:0] size_of(input logic [1:0] sz);
    logic [2:0] r;
    case (sz)
      2'b00:   r = 3'd1;
      2'b01:   r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

  // A half at an odd offset, or a word at any non-zero offset.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  // The access spills into the next word when off + size > 4.
  function automatic logic is_crossing(input logic [1:0] sz, input logic [1:0] off);
    return (({1'b0, off} + size_of(sz)) > 3'd4);
  endfunction

  // Byte lanes touched in the first word. Lanes past byte 3 are dropped.
  function automatic logic [3:0] be_beat0(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] m;
    m = ((8'd1 << size_of(sz)) - 8'd1) << off;
    return m[3:0];
  endfunction

  // Byte lanes of the spill-over word, always starting at lane 0.
  function automatic logic [3:0] be_beat1(input logic [1:0] sz, input logic [1:0] off);
    logic [2:0] hi;
    logic [7:0] m;
    hi = {1'b0, off} + size_of(sz) - 3'd4;
    m  = (8'd1 << hi) - 8'd1;
    return m[3:0];
  endfunction

  // Store data moved up to its byte lanes in the first word.
  function automatic logic [31:0] wdata_beat0(input logic [31:0] wd, input logic [1:0] off);
    return wd << {off, 3'b000};
  endfunction

  // Upper store bytes that did not fit in the first word.
  function automatic logic [31:0] wdata_beat1(input logic [31:0] wd, input logic [1:0] off);
    return wd >> (6'd32 - {1'b0, off, 3'b000});
  endfunction

  // Extract the addressed bytes from {beat1, beat0} and sign- or zero-extend them.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [63:0] raw);
    logic [31:0] lo;
    logic [31:0] r;
    lo = 32'(raw >> {off, 3'b000});
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) begin
          r = {24'h000000, lo[7:0]};
        end else begin
          r = {{24{lo[7]}}, lo[7:0]};
        end
      end
      2'b01: begin
        if (f3[2]) begin
          r = {16'h0000, lo[15:0]};
        end else begin
          r = {{16{lo[15]}}, lo[15:0]};
        end
      end
      default: r = lo;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t            state_r;
  state_t            state_nxt_s;
  logic              beat_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_b0_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r;
  logic              done_r;
  logic [31:0]       load_data_r;

  logic              exc_s;
  logic              start_s;
  logic              next_beat_s;
  logic              finish_s;
  logic              crossing_s;

  assign crossing_s = is_crossing(funct3_r[1:0], off_r);

  // Refuse misaligned requests in IDLE when the unit does not split them.
  always_comb begin
    exc_s = 1'b0;
    if ((MISALIGN_SPLIT == 1'b0) && req_valid && (state_r == ST_IDLE)) begin
      exc_s = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    end else begin
      exc_s = 1'b0;
    end
  end

  assign misalign_exc = exc_s;
  assign stall_mw     = req_valid & (state_r != ST_RESP) & ~exc_s;

  // Hold the FSM state; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Compute the next state and the one-cycle datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    next_beat_s = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && !exc_s) begin
          state_nxt_s = ST_ISSUE;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem.mem_gnt) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          if (crossing_s && !beat_r) begin
            state_nxt_s = ST_ISSUE;
            next_beat_s = 1'b1;
          end else begin
            state_nxt_s = ST_RESP;
            finish_s    = 1'b1;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        // The instruction still presented here has just been served; it is
        // not restarted, and the pipeline advances on this edge.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latch the request, drive the registered memory bus, and assemble load results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_r      <= 1'b0;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      wdata_r     <= 32'h0000_0000;
      rdata_b0_r  <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      done_r      <= 1'b0;
      load_data_r <= 32'h0000_0000;
    end else begin
      done_r <= finish_s;
      if (start_s) begin
        beat_r      <= 1'b0;
        we_r        <= req_we;
        funct3_r    <= req_funct3;
        off_r       <= req_addr[1:0];
        wdata_r     <= req_wdata;
        mem_req_r   <= 1'b1;
        mem_we_r    <= req_we;
        mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_be_r    <= be_beat0(req_funct3[1:0], req_addr[1:0]);
        mem_wdata_r <= wdata_beat0(req_wdata, req_addr[1:0]);
      end else if (next_beat_s) begin
        // The second beat goes to the following word. The address wraps at
        // the top of the address space.
        beat_r      <= 1'b1;
        rdata_b0_r  <= mem.mem_rdata;
        mem_req_r   <= 1'b1;
        mem_addr_r  <= mem_addr_r + ADDR_W'(3'd4);
        mem_be_r    <= be_beat1(funct3_r[1:0], off_r);
        mem_wdata_r <= wdata_beat1(wdata_r, off_r);
      end else if ((state_r == ST_ISSUE) && mem.mem_gnt) begin
        mem_req_r <= 1'b0;
      end else begin
        mem_req_r <= mem_req_r;
      end
      if (finish_s && !we_r) begin
        if (beat_r) begin
          load_data_r <= load_extend(funct3_r, off_r, {mem.mem_rdata, rdata_b0_r});
        end else begin
          load_data_r <= load_extend(funct3_r, off_r, {32'h0000_0000, mem.mem_rdata});
        end
      end else begin
        load_data_r <= load_data_r;
      end
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_be    = mem_be_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign done          = done_r;
  assign load_data     = load_data_r;

endmodule
